// File: rtl/ysyx_22040632_ifu_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ysyx_22040632_ifu_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned BUS_W_DEF = 64;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [XLEN-1:0] NOP_INST     = 32'h0;

  typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} ifu_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_pkt_t;

  // Address of the 64-bit beat that contains pc.
  function automatic logic [XLEN-1:0] beat_align(input logic [XLEN-1:0] pc);
    return pc & 32'hFFFF_FFF8;
  endfunction

endpackage

// File: rtl/ysyx_22040632_ifu_if.sv
// Instruction memory read port: address request channel plus read data channel.
interface ysyx_22040632_ifu_if;
  import ysyx_22040632_ifu_pkg::*;

  logic                 ar_valid;
  logic                 ar_ready;
  logic [XLEN-1:0]      ar_addr;
  logic                 r_valid;
  logic                 r_ready;
  logic [BUS_W_DEF-1:0] r_data;

  modport master (output ar_valid, ar_addr, r_ready, input ar_ready, r_valid, r_data);
  modport slave  (input ar_valid, ar_addr, r_ready, output ar_ready, r_valid, r_data);
endinterface

// File: rtl/ysyx_22040632_ifu_hold.sv
// Single-entry skid register holding a fetched instruction while decode stalls.
module ysyx_22040632_ifu_hold
  import ysyx_22040632_ifu_pkg::*;
(
  input  logic       clk,
  input  logic       rrst_n,
  input  logic       i_load,
  input  logic       i_clear,
  input  logic       i_flush,
  input  fetch_pkt_t i_pkt,
  output fetch_pkt_t o_pkt,
  output logic       o_full
);

  fetch_pkt_t r_pkt;
  logic       r_full;

  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_pkt  <= '0;
      r_full <= 1'b0;
    end else if (i_flush || i_clear) begin
      r_pkt  <= '0;
      r_full <= 1'b0;
    end else if (i_load) begin
      r_pkt  <= i_pkt;
      r_full <= 1'b1;
    end
  end

  assign o_pkt  = r_pkt;
  assign o_full = r_full;

endmodule

// File: rtl/ysyx_22040632_ifu.sv
// Instruction fetch stage: owns the fetch PC, issues one read at a time and feeds decode.
module ysyx_22040632_ifu
  import ysyx_22040632_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned BUS_W    = BUS_W_DEF
) (
  input  logic                    clk,
  input  logic                    rrst_n,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [XLEN-1:0]         redirect_pc,
  ysyx_22040632_ifu_if.master     mem,
  output logic [XLEN-1:0]         pc2id,
  output logic [XLEN-1:0]         inst2id,
  output logic                    valid2id
);

  ifu_state_t      r_state, w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc, w_fetch_pc_nxt;
  logic            r_stale, w_stale_nxt;
  logic            r_ar_valid, w_ar_valid_nxt;
  logic [XLEN-1:0] r_ar_addr, w_ar_addr_nxt;
  logic            r_r_ready;
  fetch_pkt_t      r_out, w_out_nxt;
  logic            w_out_we;
  logic            w_hold_load, w_hold_clear, w_hold_full;
  fetch_pkt_t      w_hold_pkt, w_fetch_pkt;
  logic            w_ar_hs;
  logic [XLEN-1:0] w_redir, w_pc_inc, w_sel_inst;

  assign w_ar_hs     = r_ar_valid & mem.ar_ready;
  assign w_redir     = redirect_pc & 32'hFFFF_FFFC;
  assign w_pc_inc    = r_fetch_pc + 32'd4;
  assign w_sel_inst  = r_fetch_pc[2] ? mem.r_data[BUS_W-1 -: 32] : mem.r_data[31:0];
  assign w_fetch_pkt = '{pc: r_fetch_pc, inst: w_sel_inst};

  ysyx_22040632_ifu_hold u_hold (
    .clk     (clk),
    .rrst_n  (rrst_n),
    .i_load  (w_hold_load),
    .i_clear (w_hold_clear),
    .i_flush (flush),
    .i_pkt   (w_fetch_pkt),
    .o_pkt   (w_hold_pkt),
    .o_full  (w_hold_full)
  );

  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state    <= REQ;
      r_fetch_pc <= RESET_PC;
      r_stale    <= 1'b0;
      r_ar_valid <= 1'b0;
      r_ar_addr  <= '0;
      r_r_ready  <= 1'b0;
      r_out      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_stale    <= w_stale_nxt;
      r_ar_valid <= w_ar_valid_nxt;
      r_ar_addr  <= w_ar_addr_nxt;
      r_r_ready  <= (w_state_nxt == WAIT) || (w_state_nxt == DROP);
      if (w_out_we) r_out <= w_out_nxt;
    end
  end

  // Next state, fetch PC and decode-side payload; flush always wins over stall.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_stale_nxt    = r_stale;
    w_hold_load    = 1'b0;
    w_hold_clear   = 1'b0;
    w_out_nxt      = '{pc: '0, inst: NOP_INST};
    w_out_we       = flush | ~stall;
    unique case (r_state)
      REQ: begin
        if (flush) w_fetch_pc_nxt = w_redir;
        if (w_ar_hs) begin
          w_stale_nxt = 1'b0;
          w_state_nxt = (flush || r_stale) ? DROP : WAIT;
        end else if (flush && r_ar_valid) begin
          w_stale_nxt = 1'b1;
        end
      end
      WAIT: begin
        if (flush) begin
          w_fetch_pc_nxt = w_redir;
          w_state_nxt    = mem.r_valid ? REQ : DROP;
        end else if (mem.r_valid) begin
          if (!stall) begin
            w_out_nxt      = w_fetch_pkt;
            w_fetch_pc_nxt = w_pc_inc;
            w_state_nxt    = REQ;
          end else begin
            w_hold_load = 1'b1;
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (flush) begin
          w_fetch_pc_nxt = w_redir;
          w_state_nxt    = REQ;
        end else if (!stall && w_hold_full) begin
          w_out_nxt      = w_hold_pkt;
          w_hold_clear   = 1'b1;
          w_fetch_pc_nxt = w_pc_inc;
          w_state_nxt    = REQ;
        end
      end
      DROP: begin
        if (flush) w_fetch_pc_nxt = w_redir;
        if (mem.r_valid) w_state_nxt = REQ;
      end
      default: w_state_nxt = REQ;
    endcase
    if (flush) w_out_nxt = '{pc: '0, inst: NOP_INST};
  end

  // A pending request keeps its address until accepted; otherwise entering REQ issues afresh.
  always_comb begin
    w_ar_valid_nxt = 1'b0;
    w_ar_addr_nxt  = r_ar_addr;
    if (w_state_nxt == REQ) begin
      w_ar_valid_nxt = 1'b1;
      if (!(r_state == REQ && r_ar_valid && !w_ar_hs)) begin
        w_ar_addr_nxt = beat_align(w_fetch_pc_nxt);
      end
    end
  end

  assign mem.ar_valid = r_ar_valid;
  assign mem.ar_addr  = r_ar_addr;
  assign mem.r_ready  = r_r_ready;
  assign pc2id        = r_out.pc;
  assign inst2id      = r_out.inst;
  assign valid2id     = (r_out.inst != NOP_INST) || (r_out.pc != '0);

endmodule
